tape_csw_player: RTL and testbench

Cassette-input replay engine for the SAM Coupe core. It streams a CSW-style run-length pulse image from the tape region of SDRAM through a request/acknowledge read port. It regenerates the EAR level on `tape_in`, which the ASIC keyboard/status port (254) returns in bit 6. It sits downstream of the ioctl download path (image already in SDRAM) and upstream of the ASIC read mux and audio mixer.

---
 rtl/tape_csw_player_if.sv | 11 +
 rtl/tape_csw_player.sv | 192 +++++++++++++++++++
 tb/tb_tape_csw_player.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_csw_player_if.sv
// Tape image read port: the player requests one SDRAM byte at a time and
// waits for a single-cycle acknowledge carrying the data.
interface tape_csw_player_if;
   logic        rd_req;
   logic [24:0] rd_addr;
   logic [7:0]  rd_data;
   logic        rd_ack;

   modport master (output rd_req, rd_addr, input rd_data, rd_ack);
   modport slave  (input rd_req, rd_addr, output rd_data, rd_ack);
endinterface

// File: rtl/tape_csw_player.sv
// CSW run-length tape replay: streams pulse lengths from SDRAM and toggles
// the regenerated EAR level after each run of N samples.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | stopped, waiting for play (also after eof or rewind)
// S_FETCH | reading the next run byte (nonzero = short run, 0 = extended)
// S_EXT   | reading the four little-endian bytes of an extended run
// S_RUN   | counting down the current run, toggles tape_in when it ends
// S_PAUSE | run frozen (pulse, div, tape_in held) until play toggles again
module tape_csw_player #(
   parameter int DIV = 136
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ce_tick,
   input  logic [24:0]       tape_base,
   input  logic [24:0]       tape_size,
   input  logic              tape_ready,
   input  logic              play_toggle,
   input  logic              rewind,
   tape_csw_player_if.master rd,
   output logic              tape_in,
   output logic              active,
   output logic              eof
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXT,
      S_RUN,
      S_PAUSE
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   state_t      state;
   logic [24:0] ptr;
   logic [31:0] pulse;
   logic [7:0]  div;
   logic [1:0]  ext_cnt;
   logic        pause_pend;
   logic        tape_ready_q;

   logic        rewind_evt;
   logic        rd_hit;
   logic        at_end;
   logic        pause_now;
   logic [31:0] ext_word;

   assign rewind_evt = rewind | (tape_ready_q & ~tape_ready);
   assign rd_hit     = rd.rd_req & rd.rd_ack;
   assign at_end     = (ptr >= tape_size);
   assign pause_now  = pause_pend | play_toggle;
   // Extended bytes arrive LSB first, so shifting in from the top leaves
   // the first byte in pulse[7:0] after the fourth one.
   assign ext_word   = {rd.rd_data, pulse[31:8]};
   assign rd.rd_addr = tape_base + ptr;

   always_ff @(posedge clk_sys) begin
      if (reset) tape_ready_q <= 1'b0;
      else       tape_ready_q <= tape_ready;
   end

   always_ff @(posedge clk_sys) begin
      if (reset || rewind_evt) begin
         state      <= S_IDLE;
         ptr        <= '0;
         pulse      <= '0;
         div        <= '0;
         ext_cnt    <= '0;
         pause_pend <= 1'b0;
         rd.rd_req  <= 1'b0;
         tape_in    <= 1'b0;
         active     <= 1'b0;
         eof        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (play_toggle && tape_ready && (ptr < tape_size) && !eof) begin
                  state  <= S_FETCH;
                  active <= 1'b1;
               end
            end

            S_FETCH: begin
               if (play_toggle) pause_pend <= 1'b1;
               if (!rd.rd_req) begin
                  // only reachable at the end after a skipped zero record
                  if (at_end) begin
                     state  <= S_IDLE;
                     active <= 1'b0;
                     eof    <= 1'b1;
                  end else begin
                     rd.rd_req <= 1'b1;
                  end
               end else if (rd_hit) begin
                  rd.rd_req <= 1'b0;
                  ptr       <= ptr + 25'd1;
                  if (rd.rd_data != 8'h00) begin
                     pulse <= {24'd0, rd.rd_data};
                     div   <= '0;
                     if (pause_now) begin
                        state      <= S_PAUSE;
                        active     <= 1'b0;
                        pause_pend <= 1'b0;
                     end else begin
                        state <= S_RUN;
                     end
                  end else begin
                     state   <= S_EXT;
                     ext_cnt <= '0;
                  end
               end
            end

            S_EXT: begin
               if (play_toggle) pause_pend <= 1'b1;
               if (!rd.rd_req) begin
                  if (at_end) begin
                     state  <= S_IDLE;
                     active <= 1'b0;
                     eof    <= 1'b1;
                  end else begin
                     rd.rd_req <= 1'b1;
                  end
               end else if (rd_hit) begin
                  rd.rd_req <= 1'b0;
                  ptr       <= ptr + 25'd1;
                  pulse     <= ext_word;
                  ext_cnt   <= ext_cnt + 2'd1;
                  if (ext_cnt == 2'd3) begin
                     if (ext_word != 32'd0) begin
                        div <= '0;
                        if (pause_now) begin
                           state      <= S_PAUSE;
                           active     <= 1'b0;
                           pause_pend <= 1'b0;
                        end else begin
                           state <= S_RUN;
                        end
                     end else begin
                        // zero-length record: skip without a level change,
                        // any pending pause carries over to the next record
                        state <= S_FETCH;
                     end
                  end
               end
            end

            S_RUN: begin
               if (play_toggle) begin
                  state  <= S_PAUSE;
                  active <= 1'b0;
               end else if (ce_tick) begin
                  if (div == DIV_LAST) begin
                     div   <= '0;
                     pulse <= pulse - 32'd1;
                     if (pulse == 32'd1) begin
                        tape_in <= ~tape_in;
                        if (at_end) begin
                           state  <= S_IDLE;
                           active <= 1'b0;
                           eof    <= 1'b1;
                        end else begin
                           state <= S_FETCH;
                        end
                     end
                  end else begin
                     div <= div + 8'd1;
                  end
               end
            end

            S_PAUSE: begin
               if (play_toggle) begin
                  state  <= S_RUN;
                  active <= 1'b1;
               end
            end

            default: begin
               state     <= S_IDLE;
               active    <= 1'b0;
               rd.rd_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tape_csw_player.sv
// Bench for tape_csw_player: table of tape images plus hand-written pause,
// rewind and tape_ready sequences; reads and level edges are scoreboarded.
module tb_tape_csw_player;
   localparam int          DIV  = 4;
   localparam logic [24:0] BASE = 25'h100000;

   logic        clk_sys     = 1'b0;
   logic        reset       = 1'b1;
   logic        ce_tick     = 1'b0;
   logic [24:0] tape_base   = BASE;
   logic [24:0] tape_size   = '0;
   logic        tape_ready  = 1'b1;
   logic        play_toggle = 1'b0;
   logic        rewind      = 1'b0;
   logic        tape_in, active, eof;

   tape_csw_player_if rd_if();

   tape_csw_player #(.DIV(DIV)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ce_tick     (ce_tick),
      .tape_base   (tape_base),
      .tape_size   (tape_size),
      .tape_ready  (tape_ready),
      .play_toggle (play_toggle),
      .rewind      (rewind),
      .rd          (rd_if),
      .tape_in     (tape_in),
      .active      (active),
      .eof         (eof)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [7:0] img[8];
      int         size;
      int         lat;
      int         n_edges;
      int         ticks[4];
   } vec_t;

   typedef struct {
      int   ticks;
      logic lvl;
      logic last;
   } edge_exp_t;

   vec_t        vecs[6];
   edge_exp_t   edge_q[$];
   logic [24:0] addr_q[$];
   logic [7:0]  mem[16];

   int   checks = 0;
   int   errors = 0;
   int   lat = 3;
   int   lat_cnt = 0;
   int   cyc = 0;
   int   run_ticks = 0;
   int   total_ticks = 0;
   logic force_ack = 1'b0;
   logic tb_paused = 1'b0;
   logic mon_en = 1'b0;
   logic last_tape = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Negedge process: edge scoreboard for the last posedge, then the memory
   // responder and tick for the next posedge, then run-tick accounting.
   initial begin
      logic      ack_real;
      edge_exp_t e;
      rd_if.rd_ack  = 1'b0;
      rd_if.rd_data = 8'h00;
      forever begin
         @(negedge clk_sys);
         if (!mon_en) begin
            last_tape = tape_in;
         end else if (tape_in !== last_tape) begin
            last_tape = tape_in;
            if (edge_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_edge: tape_in went to %0b, no edge expected", tape_in);
            end else begin
               e = edge_q.pop_front();
               chk("edge_ticks", run_ticks, e.ticks);
               chk("edge_level", tape_in, e.lvl);
               if (e.last) begin
                  chk("eof_with_last_edge", eof, 1);
                  chk("active_with_last_edge", active, 0);
               end
            end
         end

         ack_real      = 1'b0;
         rd_if.rd_ack  = force_ack;
         if (force_ack) rd_if.rd_data = 8'h07;
         if (rd_if.rd_req) begin
            if (lat_cnt >= lat - 1) begin
               ack_real      = 1'b1;
               rd_if.rd_ack  = 1'b1;
               rd_if.rd_data = mem[4'(rd_if.rd_addr - BASE)];
               if (addr_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_read: rd_addr=%0h, no read expected", rd_if.rd_addr);
               end else begin
                  chk("rd_addr", rd_if.rd_addr, addr_q.pop_front());
               end
            end else begin
               lat_cnt++;
            end
         end else begin
            lat_cnt = 0;
         end
         cyc++;
         ce_tick = (cyc % 3 == 0);

         if (ce_tick) total_ticks++;
         if (ack_real) run_ticks = 0;
         else if (ce_tick && !play_toggle && !tb_paused) run_ticks++;
      end
   end

   task automatic pulse_play();
      play_toggle = 1'b1;
      step();
      play_toggle = 1'b0;
   endtask

   task automatic do_rewind();
      mon_en = 1'b0;
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      step();
      tb_paused = 1'b0;
      edge_q.delete();
      addr_q.delete();
   endtask

   task automatic wait_eof(input string name);
      int n = 0;
      while (!eof && n < 5000) begin
         step();
         n++;
      end
      chk(name, eof, 1);
   endtask

   task automatic push_edge(input int ticks, input logic lvl, input logic last);
      edge_exp_t e;
      e.ticks = ticks;
      e.lvl   = lvl;
      e.last  = last;
      edge_q.push_back(e);
   endtask

   task automatic run_vec(input int idx);
      vec_t v = vecs[idx];
      do_rewind();
      for (int i = 0; i < 8; i++) mem[i] = v.img[i];
      tape_size = 25'(v.size);
      lat       = v.lat;
      for (int i = 0; i < v.size; i++) addr_q.push_back(BASE + 25'(i));
      for (int k = 0; k < v.n_edges; k++)
         push_edge(v.ticks[k] * DIV, (k % 2 == 0), (k == v.n_edges - 1));
      mon_en = 1'b1;
      pulse_play();
      wait_eof("vec_eof");
      step();
      chk("vec_reads_done", addr_q.size(), 0);
      chk("vec_edges_done", edge_q.size(), 0);
      chk("vec_final_level", tape_in, v.n_edges % 2);
      chk("vec_active_end", active, 0);
      chk("vec_rd_req_end", rd_if.rd_req, 0);
   endtask

   initial begin
      int n;
      vecs[0] = '{img: '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  size: 2, lat: 3, n_edges: 2, ticks: '{3, 5, 0, 0}};
      vecs[1] = '{img: '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00},
                  size: 6, lat: 1, n_edges: 2, ticks: '{16, 2, 0, 0}};
      vecs[2] = '{img: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00},
                  size: 6, lat: 2, n_edges: 1, ticks: '{3, 0, 0, 0}};
      vecs[3] = '{img: '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  size: 3, lat: 4, n_edges: 3, ticks: '{1, 1, 1, 0}};
      vecs[4] = '{img: '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  size: 2, lat: 3, n_edges: 2, ticks: '{2, 2, 0, 0}};
      vecs[5] = '{img: '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  size: 3, lat: 2, n_edges: 0, ticks: '{0, 0, 0, 0}};

      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_rd_req", rd_if.rd_req, 0);
      chk("rst_rd_addr", rd_if.rd_addr, BASE);
      chk("rst_tape_in", tape_in, 0);
      chk("rst_active", active, 0);
      chk("rst_eof", eof, 0);

      for (int i = 0; i < 6; i++) run_vec(i);

      // last vector left eof set: play must be ignored
      pulse_play();
      repeat (4) step();
      chk("eof_play_rd_req", rd_if.rd_req, 0);
      chk("eof_play_active", active, 0);
      chk("eof_sticky", eof, 1);

      // play_toggle -> rd_req latency
      do_rewind();
      mem[0] = 8'h04;
      tape_size = 25'd1;
      lat = 2;
      addr_q.push_back(BASE);
      push_edge(4 * DIV, 1'b1, 1'b1);
      mon_en = 1'b1;
      play_toggle = 1'b1;
      step();
      play_toggle = 1'b0;
      chk("play_lat_c1", rd_if.rd_req, 0);
      step();
      chk("play_lat_c2", rd_if.rd_req, 1);

      // pause with two samples left, hold 1000 ticks, resume
      n = 0;
      while (!(addr_q.size() == 0 && run_ticks == 2 * DIV) && n < 2000) begin
         step();
         n++;
      end
      chk("pause_reach_mid_run", run_ticks, 2 * DIV);
      play_toggle = 1'b1;
      tb_paused = 1'b1;
      step();
      play_toggle = 1'b0;
      n = total_ticks;
      while (total_ticks < n + 1000) step();
      chk("pause_tape_in", tape_in, 0);
      chk("pause_active", active, 0);
      chk("pause_rd_req", rd_if.rd_req, 0);
      play_toggle = 1'b1;
      tb_paused = 1'b0;
      step();
      play_toggle = 1'b0;
      wait_eof("pause_eof");
      step();
      chk("pause_edges_done", edge_q.size(), 0);

      // toggle during FETCH: pause entered after the ack
      do_rewind();
      mem[0] = 8'h02;
      mem[1] = 8'h02;
      tape_size = 25'd2;
      lat = 4;
      addr_q.push_back(BASE);
      addr_q.push_back(BASE + 25'd1);
      push_edge(2 * DIV, 1'b1, 1'b0);
      push_edge(2 * DIV, 1'b0, 1'b1);
      mon_en = 1'b1;
      pulse_play();
      n = 0;
      while (!rd_if.rd_req && n < 50) begin
         step();
         n++;
      end
      chk("fpause_rd_req_up", rd_if.rd_req, 1);
      play_toggle = 1'b1;
      tb_paused = 1'b1;
      step();
      play_toggle = 1'b0;
      n = 0;
      while (addr_q.size() != 1 && n < 50) begin
         step();
         n++;
      end
      chk("fpause_first_read", addr_q.size(), 1);
      repeat (30) step();
      chk("fpause_active", active, 0);
      chk("fpause_rd_req", rd_if.rd_req, 0);
      chk("fpause_tape_in", tape_in, 0);
      play_toggle = 1'b1;
      tb_paused = 1'b0;
      step();
      play_toggle = 1'b0;
      wait_eof("fpause_eof");
      step();
      chk("fpause_edges_done", edge_q.size(), 0);
      chk("fpause_reads_done", addr_q.size(), 0);

      // rewind during the second fetch, then a late ack
      do_rewind();
      mem[0] = 8'h01;
      mem[1] = 8'h03;
      tape_size = 25'd2;
      lat = 5;
      addr_q.push_back(BASE);
      push_edge(1 * DIV, 1'b1, 1'b0);
      mon_en = 1'b1;
      pulse_play();
      n = 0;
      while (!(tape_in && rd_if.rd_req) && n < 200) begin
         step();
         n++;
      end
      chk("rw_second_fetch", rd_if.rd_addr, BASE + 25'd1);
      step();
      mon_en = 1'b0;
      rewind = 1'b1;
      step();
      rewind = 1'b0;
      chk("rw_rd_req_drop", rd_if.rd_req, 0);
      chk("rw_tape_in", tape_in, 0);
      chk("rw_ptr_zero", rd_if.rd_addr, BASE);
      chk("rw_active", active, 0);
      force_ack = 1'b1;
      step();
      force_ack = 1'b0;
      repeat (10) step();
      chk("late_ack_rd_req", rd_if.rd_req, 0);
      chk("late_ack_active", active, 0);
      chk("late_ack_addr", rd_if.rd_addr, BASE);
      chk("late_ack_tape_in", tape_in, 0);

      // rewind and play in the same cycle
      rewind = 1'b1;
      play_toggle = 1'b1;
      step();
      rewind = 1'b0;
      play_toggle = 1'b0;
      repeat (4) step();
      chk("rw_play_active", active, 0);
      chk("rw_play_rd_req", rd_if.rd_req, 0);

      // empty image never starts
      do_rewind();
      tape_size = 25'd0;
      pulse_play();
      repeat (4) step();
      chk("size0_active", active, 0);
      chk("size0_rd_req", rd_if.rd_req, 0);

      // tape_ready falling mid-run rewinds
      do_rewind();
      mem[0] = 8'h01;
      mem[1] = 8'h20;
      tape_size = 25'd2;
      lat = 2;
      addr_q.push_back(BASE);
      addr_q.push_back(BASE + 25'd1);
      push_edge(1 * DIV, 1'b1, 1'b0);
      mon_en = 1'b1;
      pulse_play();
      n = 0;
      while (addr_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      chk("rdy_second_read", addr_q.size(), 0);
      repeat (3) step();
      chk("rdy_running_level", tape_in, 1);
      mon_en = 1'b0;
      tape_ready = 1'b0;
      step();
      chk("rdy_fall_tape_in", tape_in, 0);
      chk("rdy_fall_active", active, 0);
      chk("rdy_fall_addr", rd_if.rd_addr, BASE);
      tape_ready = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
